// File: rtl/hs32_memarb.sv
`default_nettype none
// ============================================================================
// Module   : hs32_memarb
// Brief    : N-channel memory arbiter in front of one valid/ready memory bus.
//            Serialises one transaction at a time using fixed-priority or
//            round-robin arbitration (RR parameter).
//            Optional macro HS32_MEMARB_TIMEOUT_EN adds a ready timeout that
//            aborts the transaction and flags it on err_c.
// Revision : 1.0 - initial release
// ============================================================================
module hs32_memarb #(
    parameter int NCH     = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RR      = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic [NCH*AW-1:0] addr_c,
    input  logic [NCH*DW-1:0] dtw_c,
    input  logic [NCH-1:0]    rw_c,
    input  logic [NCH-1:0]    req_c,
    output logic [NCH-1:0]    rdy_c,
    output logic [DW-1:0]     dtr,
`ifdef HS32_MEMARB_TIMEOUT_EN
    output logic [NCH-1:0]    err_c,
`endif
    output logic [AW-1:0]     addr,
    output logic              rw,
    output logic [DW-1:0]     dout,
    output logic              valid,
    input  logic [DW-1:0]     din,
    input  logic              ready
);

    localparam int                c_IW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [c_IW:0]     c_NCH     = (c_IW + 1)'(NCH);
    localparam logic [NCH-1:0]    c_ONE_HOT = NCH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Registered state and its next-state values
    state_t            r_state_q, w_state_d;
    logic [c_IW-1:0]   r_idx_q,   w_idx_d;
    logic [c_IW-1:0]   r_ptr_q,   w_ptr_d;
    logic [AW-1:0]     r_addr_q,  w_addr_d;
    logic              r_rw_q,    w_rw_d;
    logic [DW-1:0]     r_dout_q,  w_dout_d;
    logic              r_valid_q, w_valid_d;
    logic [DW-1:0]     r_dtr_q,   w_dtr_d;
    logic [NCH-1:0]    r_rdy_q,   w_rdy_d;

`ifdef HS32_MEMARB_TIMEOUT_EN
    localparam int     c_CW = (TIMEOUT < 256) ? 8 : 16;
    logic [c_CW-1:0]   r_cnt_q,   w_cnt_d;
    logic [NCH-1:0]    r_err_q,   w_err_d;
`endif

    // Arbitration signals
    logic [c_IW-1:0]   w_base;
    logic [2*NCH-1:0]  w_req_dbl;
    logic [NCH-1:0]    w_req_rot;
    logic [c_IW-1:0]   w_off;
    logic [c_IW:0]     w_sum;
    logic [c_IW-1:0]   w_win;
    logic [c_IW:0]     w_inc;
    logic [c_IW-1:0]   w_ptr_nxt;
    logic              w_any;

    // Winner search: rotate the request vector so the search base sits at
    // bit 0, take the lowest set bit, then rotate the offset back.
    always_comb begin
        w_base    = (RR != 0) ? r_ptr_q : '0;
        w_req_dbl = {req_c, req_c} >> w_base;
        w_req_rot = w_req_dbl[NCH-1:0];
        w_any     = |req_c;
        w_off     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_off = c_IW'(i);
            end
        end
        w_sum = {1'b0, w_base} + {1'b0, w_off};
        if (w_sum >= c_NCH) begin
            w_sum = w_sum - c_NCH;
        end
        w_win = w_sum[c_IW-1:0];
        w_inc = {1'b0, w_win} + (c_IW + 1)'(1);
        if (w_inc == c_NCH) begin
            w_inc = '0;
        end
        w_ptr_nxt = w_inc[c_IW-1:0];
    end

    // Next-state and datapath logic for the IDLE -> BUSY -> DONE sequence
    always_comb begin
        w_state_d = r_state_q;
        w_idx_d   = r_idx_q;
        w_ptr_d   = r_ptr_q;
        w_addr_d  = r_addr_q;
        w_rw_d    = r_rw_q;
        w_dout_d  = r_dout_q;
        w_valid_d = r_valid_q;
        w_dtr_d   = r_dtr_q;
        w_rdy_d   = '0;
`ifdef HS32_MEMARB_TIMEOUT_EN
        w_cnt_d   = r_cnt_q;
        w_err_d   = '0;
`endif
        case (r_state_q)
            ST_IDLE: begin
                w_valid_d = 1'b0;
                if (w_any) begin
                    w_idx_d = w_win;
                    for (int i = 0; i < NCH; i++) begin
                        if (w_win == c_IW'(i)) begin
                            w_addr_d = addr_c[i*AW +: AW];
                            w_dout_d = dtw_c[i*DW +: DW];
                            w_rw_d   = rw_c[i];
                        end
                    end
                    if (RR != 0) begin
                        w_ptr_d = w_ptr_nxt;
                    end
                    w_valid_d = 1'b1;
                    w_state_d = ST_BUSY;
`ifdef HS32_MEMARB_TIMEOUT_EN
                    w_cnt_d   = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (ready) begin
                    // Normal completion wins even on the timeout cycle
                    w_valid_d = 1'b0;
                    if (!r_rw_q) begin
                        w_dtr_d = din;
                    end
                    w_rdy_d   = c_ONE_HOT << r_idx_q;
                    w_state_d = ST_DONE;
                end
`ifdef HS32_MEMARB_TIMEOUT_EN
                else if (r_cnt_q == c_CW'(TIMEOUT - 1)) begin
                    // Abort: valid has been high for TIMEOUT cycles
                    w_valid_d = 1'b0;
                    w_rdy_d   = c_ONE_HOT << r_idx_q;
                    w_err_d   = c_ONE_HOT << r_idx_q;
                    w_state_d = ST_DONE;
                end else begin
                    w_cnt_d = r_cnt_q + c_CW'(1);
                end
`endif
            end
            ST_DONE: begin
                // Single completion cycle; no grant here so a stale req is
                // never re-served
                w_state_d = ST_IDLE;
            end
            default: begin
                w_valid_d = 1'b0;
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!reset) begin
            r_state_q <= ST_IDLE;
            r_idx_q   <= '0;
            r_ptr_q   <= '0;
            r_addr_q  <= '0;
            r_rw_q    <= 1'b0;
            r_dout_q  <= '0;
            r_valid_q <= 1'b0;
            r_dtr_q   <= '0;
            r_rdy_q   <= '0;
`ifdef HS32_MEMARB_TIMEOUT_EN
            r_cnt_q   <= '0;
            r_err_q   <= '0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
            r_ptr_q   <= w_ptr_d;
            r_addr_q  <= w_addr_d;
            r_rw_q    <= w_rw_d;
            r_dout_q  <= w_dout_d;
            r_valid_q <= w_valid_d;
            r_dtr_q   <= w_dtr_d;
            r_rdy_q   <= w_rdy_d;
`ifdef HS32_MEMARB_TIMEOUT_EN
            r_cnt_q   <= w_cnt_d;
            r_err_q   <= w_err_d;
`endif
        end
    end

    assign rdy_c = r_rdy_q;
    assign dtr   = r_dtr_q;
    assign addr  = r_addr_q;
    assign rw    = r_rw_q;
    assign dout  = r_dout_q;
    assign valid = r_valid_q;
`ifdef HS32_MEMARB_TIMEOUT_EN
    assign err_c = r_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hs32_memarb.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs32_memarb
// Brief    : Directed self-checking bench for hs32_memarb. One round-robin
//            instance and one fixed-priority instance share the channel
//            address/data/direction inputs. Timeout steps are compiled in
//            when HS32_MEMARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hs32_memarb;

    logic          clk;
    logic          reset;
    logic [127:0]  addr_c;
    logic [127:0]  dtw_c;
    logic [3:0]    rw_c;

    logic [3:0]    req_r,   req_f;
    logic [3:0]    rdy_r,   rdy_f;
    logic [31:0]   dtr_r,   dtr_f;
    logic [31:0]   addr_r,  addr_f;
    logic          rw_r,    rw_f;
    logic [31:0]   dout_r,  dout_f;
    logic          valid_r, valid_f;
    logic [31:0]   din_r,   din_f;
    logic          ready_r, ready_f;
`ifdef HS32_MEMARB_TIMEOUT_EN
    logic [3:0]    err_r,   err_f;
`endif

    int checks = 0;
    int errors = 0;

    hs32_memarb #(.NCH(4), .AW(32), .DW(32), .RR(1), .TIMEOUT(10)) u_rr (
        .i_clk  (clk),
        .reset  (reset),
        .addr_c (addr_c),
        .dtw_c  (dtw_c),
        .rw_c   (rw_c),
        .req_c  (req_r),
        .rdy_c  (rdy_r),
        .dtr    (dtr_r),
`ifdef HS32_MEMARB_TIMEOUT_EN
        .err_c  (err_r),
`endif
        .addr   (addr_r),
        .rw     (rw_r),
        .dout   (dout_r),
        .valid  (valid_r),
        .din    (din_r),
        .ready  (ready_r)
    );

    hs32_memarb #(.NCH(4), .AW(32), .DW(32), .RR(0), .TIMEOUT(10)) u_fp (
        .i_clk  (clk),
        .reset  (reset),
        .addr_c (addr_c),
        .dtw_c  (dtw_c),
        .rw_c   (rw_c),
        .req_c  (req_f),
        .rdy_c  (rdy_f),
        .dtr    (dtr_f),
`ifdef HS32_MEMARB_TIMEOUT_EN
        .err_c  (err_f),
`endif
        .addr   (addr_f),
        .rw     (rw_f),
        .dout   (dout_f),
        .valid  (valid_f),
        .din    (din_f),
        .ready  (ready_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // At most one completion pulse may be visible at any time
    always @(negedge clk) begin
        checks++;
        assert ($onehot0(rdy_r) && $onehot0(rdy_f)) else begin
            errors++;
            $error("FAIL rdy_onehot observed=%0h/%0h expected=onehot0", rdy_r, rdy_f);
        end
    end

    initial begin
        logic [3:0] exp_rdy;
        int         e;

        reset   = 1'b0;
        req_r   = '0;
        req_f   = '0;
        addr_c  = '0;
        dtw_c   = '0;
        rw_c    = '0;
        ready_r = 1'b0;
        din_r   = '0;
        ready_f = 1'b1;
        din_f   = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_valid", valid_r, 1'b0);
        chk("rst_rdy",   rdy_r,   4'h0);
        chk("rst_addr",  addr_r,  32'h0);
        chk("rst_rw",    rw_r,    1'b0);
        chk("rst_dout",  dout_r,  32'h0);
        chk("rst_dtr",   dtr_r,   32'h0);
        chk("rst_valid_fp", valid_f, 1'b0);

        // Single read on channel 0
        reset          = 1'b1;
        req_r          = 4'b0001;
        addr_c[31:0]   = 32'h100;
        @(negedge clk);
        chk("rd_valid", valid_r, 1'b1);
        chk("rd_addr",  addr_r,  32'h100);
        chk("rd_rdy_early", rdy_r, 4'h0);
        ready_r = 1'b1;
        din_r   = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd_rdy",   rdy_r,   4'b0001);
        chk("rd_dtr",   dtr_r,   32'hDEADBEEF);
        chk("rd_valid_drop", valid_r, 1'b0);
        req_r   = '0;
        ready_r = 1'b0;
        din_r   = '0;
        @(negedge clk);
        chk("rd_rdy_end", rdy_r, 4'h0);
        chk("rd_dtr_hold", dtr_r, 32'hDEADBEEF);

        // Channel 2 write, ready delayed; other channels toggle and the
        // winner drops its request while busy
        req_r          = 4'b0100;
        addr_c[95:64]  = 32'h2000;
        dtw_c[95:64]   = 32'h12345678;
        rw_c           = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wr_valid", valid_r, 1'b1);
            chk("wr_addr",  addr_r,  32'h2000);
            chk("wr_rw",    rw_r,    1'b1);
            chk("wr_dout",  dout_r,  32'h12345678);
            chk("wr_rdy",   rdy_r,   4'h0);
            if (i == 1) req_r = 4'b0101;
            if (i == 2) req_r = 4'b0001;
        end
        ready_r = 1'b1;
        din_r   = 32'hAAAA5555;
        req_r   = '0;
        @(negedge clk);
        chk("wr_rdy_pulse", rdy_r,   4'b0100);
        chk("wr_valid_drop", valid_r, 1'b0);
        chk("wr_dtr_hold",  dtr_r,   32'hDEADBEEF);
        ready_r = 1'b0;
        @(negedge clk);
        chk("wr_rdy_end", rdy_r, 4'h0);
        chk("wr_idle_valid", valid_r, 1'b0);

        // Reset during BUSY; pointer is at 3 so channel 1 wins by wrap
        rw_c           = '0;
        req_r          = 4'b0010;
        addr_c[63:32]  = 32'h300;
        @(negedge clk);
        chk("rm_valid", valid_r, 1'b1);
        chk("rm_addr",  addr_r,  32'h300);
        reset = 1'b0;
        req_r = '0;
        @(negedge clk);
        chk("rm_valid_rst", valid_r, 1'b0);
        chk("rm_rdy_rst",   rdy_r,   4'h0);
        chk("rm_addr_rst",  addr_r,  32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("rm_rdy_after1", rdy_r, 4'h0);
        @(negedge clk);
        chk("rm_rdy_after2", rdy_r, 4'h0);
        chk("rm_valid_after", valid_r, 1'b0);

        // Round robin from a freshly reset pointer, zero-wait ready
        for (int k = 0; k < 4; k++) addr_c[k*32 +: 32] = 32'h1000 + k;
        din_r   = 32'hD0000000;
        ready_r = 1'b1;
        req_r   = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            e       = g % 4;
            exp_rdy = 4'b0001 << e;
            @(negedge clk);
            chk("rr_valid", valid_r, 1'b1);
            chk("rr_addr",  addr_r,  32'h1000 + e);
            @(negedge clk);
            chk("rr_rdy",   rdy_r,   exp_rdy);
            chk("rr_valid_drop", valid_r, 1'b0);
            @(negedge clk);
            chk("rr_rdy_end", rdy_r, 4'h0);
        end
        req_r = '0;
        @(negedge clk);
        chk("rr_ready_ignored_rdy",   rdy_r,   4'h0);
        chk("rr_ready_ignored_valid", valid_r, 1'b0);
        chk("rr_dtr", dtr_r, 32'hD0000000);
        ready_r = 1'b0;

        // Fixed priority: channel 1 starves channel 2 until it drops
        req_f = 4'b0110;
        for (int g = 0; g < 4; g++) begin
            e       = (g < 3) ? 1 : 2;
            exp_rdy = 4'b0001 << e;
            @(negedge clk);
            chk("fp_valid", valid_f, 1'b1);
            chk("fp_addr",  addr_f,  32'h1000 + e);
            @(negedge clk);
            chk("fp_rdy",   rdy_f,   exp_rdy);
            @(negedge clk);
            chk("fp_rdy_end", rdy_f, 4'h0);
            if (g == 2) req_f = 4'b0100;
        end
        req_f = '0;
        @(negedge clk);

`ifdef HS32_MEMARB_TIMEOUT_EN
        // Timeout: ready never arrives; pointer is at 1 so channel 0 wins
        req_r = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("to_valid", valid_r, 1'b1);
            chk("to_err_busy", err_r, 4'h0);
        end
        @(negedge clk);
        chk("to_valid_drop", valid_r, 1'b0);
        chk("to_rdy",        rdy_r,   4'b0001);
        chk("to_err",        err_r,   4'b0001);
        chk("to_dtr_hold",   dtr_r,   32'hD0000000);
        req_r = '0;
        @(negedge clk);
        chk("to_rdy_end", rdy_r, 4'h0);
        chk("to_err_end", err_r, 4'h0);
        req_r   = 4'b0010;
        ready_r = 1'b1;
        din_r   = 32'h5A5A5A5A;
        @(negedge clk);
        chk("to_next_valid", valid_r, 1'b1);
        chk("to_next_addr",  addr_r,  32'h1001);
        @(negedge clk);
        chk("to_next_rdy",   rdy_r,   4'b0010);
        chk("to_next_err",   err_r,   4'h0);
        chk("to_next_dtr",   dtr_r,   32'h5A5A5A5A);
        req_r   = '0;
        ready_r = 1'b0;
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
